// File: rtl/perf_counter_reader.sv
// Performance counter sweep initiator: reads (and optionally clears)
// each counter in the bank and streams the values out on valid/ready.
module perf_counter_reader #(
  parameter int          width        = 32,
  parameter int          NUM_COUNTERS = 9,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] IDLE_ADDR    = 32'hFFFF_FFFF,
  localparam int         IW           =
    (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear_en,
  output logic [31:0]      pc_address,
  output logic             pc_write,
  output logic [width-1:0] pc_datain,
  input  logic [width-1:0] pc_dataout,
  input  logic             pc_hit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [IW-1:0]    out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             miss_err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_t;

  localparam logic [IW-1:0] LAST_IDX =
    IW'(NUM_COUNTERS - 1);

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic          clr_q;
  logic          xfer;

  assign xfer = (state == PRESENT) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
        end
      end
      FETCH: begin
        state_n = PRESENT;
      end
      PRESENT: begin
        if (xfer) begin
          state_n = out_last ? DONE : FETCH;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      clr_q     <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      miss_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            clr_q    <= clear_en;
            idx      <= '0;
            miss_err <= 1'b0;
          end
        end
        FETCH: begin
          out_data  <= pc_dataout;
          out_index <= idx;
          out_last  <= (idx == LAST_IDX);
          miss_err  <= miss_err | ~pc_hit;
        end
        PRESENT: begin
          if (xfer && !out_last) begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

  // Write is gated by rst so a reset landing on a FETCH cannot clear.
  always_comb begin
    pc_address = IDLE_ADDR;
    pc_write   = 1'b0;
    pc_datain  = '0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
      end
      FETCH: begin
        pc_address = BASE_ADDR + 32'(idx);
        pc_write   = clr_q & ~rst;
        busy       = 1'b1;
      end
      PRESENT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Bench for perf_counter_reader: 9-counter bank model, scoreboard
// of expected beats, table of sweep cases plus reset/start corners.
module tb_perf_counter_reader;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst, start, clear_en, out_ready;
  logic sel, do_load;

  logic [31:0] a_addr, b_addr;
  logic        a_wr, b_wr;
  logic [31:0] a_din, b_din;
  logic        a_valid, b_valid;
  logic [31:0] a_data, b_data;
  logic [3:0]  a_idx, b_idx;
  logic        a_last, b_last;
  logic        a_busy, b_busy;
  logic        a_done, b_done;
  logic        a_miss, b_miss;

  logic [31:0] bank_addr, bank_din, bank_dout;
  logic        bank_wr, bank_hit;
  logic [31:0] mem [9];
  int          wr_cnt [9];
  int          bad_wr;

  logic [31:0] m_addr, m_data;
  logic [3:0]  m_idx;
  logic        m_wr, m_valid, m_last;
  logic        m_busy, m_done, m_miss;

  always #5 clk = ~clk;

  perf_counter_reader dut_a (
    .clk(clk), .rst(rst),
    .start(start & ~sel), .clear_en(clear_en),
    .pc_address(a_addr), .pc_write(a_wr),
    .pc_datain(a_din), .pc_dataout(bank_dout),
    .pc_hit(bank_hit), .out_valid(a_valid),
    .out_ready(out_ready), .out_data(a_data),
    .out_index(a_idx), .out_last(a_last),
    .busy(a_busy), .done(a_done), .miss_err(a_miss)
  );

  perf_counter_reader #(.NUM_COUNTERS(10)) dut_b (
    .clk(clk), .rst(rst),
    .start(start & sel), .clear_en(clear_en),
    .pc_address(b_addr), .pc_write(b_wr),
    .pc_datain(b_din), .pc_dataout(bank_dout),
    .pc_hit(bank_hit), .out_valid(b_valid),
    .out_ready(out_ready), .out_data(b_data),
    .out_index(b_idx), .out_last(b_last),
    .busy(b_busy), .done(b_done), .miss_err(b_miss)
  );

  assign bank_addr = sel ? b_addr : a_addr;
  assign bank_wr   = sel ? b_wr : a_wr;
  assign bank_din  = sel ? b_din : a_din;
  assign m_addr    = bank_addr;
  assign m_wr      = bank_wr;
  assign m_valid   = sel ? b_valid : a_valid;
  assign m_data    = sel ? b_data : a_data;
  assign m_idx     = sel ? b_idx : a_idx;
  assign m_last    = sel ? b_last : a_last;
  assign m_busy    = sel ? b_busy : a_busy;
  assign m_done    = sel ? b_done : a_done;
  assign m_miss    = sel ? b_miss : a_miss;

  assign bank_hit  = bank_addr < 32'd9;
  assign bank_dout = bank_hit ? mem[bank_addr[3:0]] : 32'd0;

  // Bank writes are legal only as a zero write during a FETCH.
  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < 9; i++) begin
        mem[i]    <= 32'(10 + i);
        wr_cnt[i] <= 0;
      end
      bad_wr <= 0;
    end else if (bank_wr) begin
      if (bank_hit) begin
        mem[bank_addr[3:0]]    <= bank_din;
        wr_cnt[bank_addr[3:0]] <= wr_cnt[bank_addr[3:0]] + 1;
      end
      if (bank_din != 0 || !(m_busy && !m_valid))
        bad_wr <= bad_wr + 1;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  typedef struct {
    logic sel;
    logic clr;
    int   stall;
    int   n;
    logic miss;
  } case_t;

  beat_t sb [$];
  int    checks = 0;
  int    errors = 0;
  int    stall_idx = -1;
  int    stall_cnt = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic load();
    @(negedge clk);
    do_load = 1'b1;
    @(posedge clk);
    #1 do_load = 1'b0;
  endtask

  task automatic monitor();
    beat_t b;
    forever begin
      @(negedge clk);
      if (m_valid && int'(m_idx) == stall_idx
          && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      if (m_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", {60'd0, m_idx}, 64'hFFFF);
        end else begin
          b = sb[0];
          chk("beat_data", m_data, b.data);
          chk("beat_index", m_idx, b.idx);
          chk("beat_last", m_last, b.last);
          if (!out_ready) begin
            chk("stall_addr", m_addr, IDLE);
            chk("stall_wr", m_wr, 1'b0);
          end else begin
            void'(sb.pop_front());
          end
        end
      end
    end
  endtask

  task automatic run_sweep(input logic s, input logic c,
                           input int stall, input bit poke,
                           output int cyc);
    int n;
    beat_t b;
    sel       = s;
    clear_en  = c;
    stall_idx = stall;
    stall_cnt = 0;
    n = s ? 10 : 9;
    for (int i = 0; i < n; i++) begin
      b.data = (i < 9) ? 32'(10 + i) : 32'd0;
      b.idx  = 4'(i);
      b.last = (i == n - 1);
      sb.push_back(b);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    clear_en = ~c;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("fetch0_miss_clr", m_miss, 1'b0);
        chk("fetch0_busy", m_busy, 1'b1);
        chk("fetch0_addr", m_addr, 32'd0);
        chk("fetch0_wr", m_wr, c);
      end
      if (poke && cyc == 4) start = 1'b1;
      if (poke && cyc == 5) start = 1'b0;
    end while (!m_done && cyc < 300);
    chk("done_cycle", 64'(cyc),
        64'(2 * n + 1 + ((stall >= 0) ? 5 : 0)));
    chk("done_busy", m_busy, 1'b0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("miss_err", m_miss, n > 9);
  endtask

  case_t cases [5];
  int    cyc;
  int    seen;

  initial begin
    rst = 1'b1; start = 1'b0; clear_en = 1'b0;
    out_ready = 1'b1; sel = 1'b0; do_load = 1'b0;
    cases[0] = '{1'b0, 1'b0, -1, 9, 1'b0};
    cases[1] = '{1'b0, 1'b1, -1, 9, 1'b0};
    cases[2] = '{1'b0, 1'b0, 3, 9, 1'b0};
    cases[3] = '{1'b1, 1'b0, -1, 10, 1'b1};
    cases[4] = '{1'b1, 1'b1, -1, 10, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_miss", a_miss, 1'b0);
    chk("rst_data", a_data, 32'd0);
    chk("rst_index", a_idx, 4'd0);
    chk("rst_last", a_last, 1'b0);
    chk("rst_addr", a_addr, IDLE);
    chk("rst_wr", a_wr, 1'b0);
    chk("rst_din", a_din, 32'd0);
    chk("rst_b_addr", b_addr, IDLE);
    fork
      monitor();
    join_none

    for (int k = 0; k < 5; k++) begin
      load();
      run_sweep(cases[k].sel, cases[k].clr,
                cases[k].stall, 1'b0, cyc);
      @(negedge clk);
      chk("miss_held", m_miss, cases[k].miss);
      for (int i = 0; i < 9; i++) begin
        chk("mem_after", mem[i],
            cases[k].clr ? 32'd0 : 32'(10 + i));
        chk("wr_count", 64'(wr_cnt[i]),
            64'(cases[k].clr));
      end
      chk("bad_writes", 64'(bad_wr), 64'd0);
    end

    sel = 1'b0;
    load();
    stall_idx = -1;
    begin
      beat_t b;
      for (int i = 0; i < 9; i++) begin
        b.data = 32'(10 + i);
        b.idx  = 4'(i);
        b.last = (i == 8);
        sb.push_back(b);
      end
    end
    clear_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(m_valid && m_idx == 4'd4) && cyc < 100);
    chk("rst_reach_idx4", m_idx, 4'd4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_valid", m_valid, 1'b0);
    chk("mrst_busy", m_busy, 1'b0);
    chk("mrst_wr", m_wr, 1'b0);
    chk("mrst_data", m_data, 32'd0);
    chk("mrst_addr", m_addr, IDLE);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_done || m_busy) seen++;
    end
    chk("mrst_no_done", 64'(seen), 64'd0);
    sb.delete();
    for (int i = 0; i < 9; i++) begin
      chk("mrst_mem", mem[i],
          (i < 5) ? 32'd0 : 32'(10 + i));
      chk("mrst_wr_cnt", 64'(wr_cnt[i]),
          64'((i < 5) ? 1 : 0));
    end

    load();
    run_sweep(1'b0, 1'b0, -1, 1'b1, cyc);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("done_start_busy", m_busy, 1'b0);
    chk("done_start_valid", m_valid, 1'b0);
    run_sweep(1'b0, 1'b1, -1, 1'b0, cyc);
    repeat (5) @(negedge clk);
    chk("final_idle", m_busy, 1'b0);
    chk("final_sb", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 9; i++)
      chk("final_mem", mem[i], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
